// File: rtl/dl_enc_pkg.sv
// Shared widths and types for the 32-to-5 pending encoder and its helpers.
// No logic, types only.
// Not applicable: no handshake lives here.
package dl_enc_pkg;
    localparam int ENC_IDX_W = 5;
    localparam int ENC_VEC_W = 32;

    typedef logic [ENC_IDX_W-1:0] enc_idx_t;
    typedef logic [ENC_VEC_W-1:0] enc_vec_t;
endpackage

// File: rtl/dl_decoder_5p32p.sv
// 5-to-32 one-hot decoder.
// Latency: combinational.
// Backpressure: none, pure function of the index.
module dl_decoder_5p32p
    import dl_enc_pkg::*;
(
    input  enc_idx_t idx_i,
    output enc_vec_t onehot_o
);
    assign onehot_o = enc_vec_t'(1) << idx_i;
endmodule

// File: rtl/dl_prienc_32p5p.sv
// 32-to-5 priority encoder: lowest set bit wins, plus an any-set flag.
// Latency: combinational.
// Backpressure: none, pure function of the vector.
module dl_prienc_32p5p
    import dl_enc_pkg::*;
(
    input  enc_vec_t vec_i,
    output enc_idx_t idx_o,
    output logic     any_o
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = ENC_VEC_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = enc_idx_t'(i);
            end
        end
    end
endmodule

// File: rtl/dl_pend_encoder_32p5p.sv
// Collects 32 request pulses into a pending set and emits them as a 5-bit index stream, lowest first.
// Latency: set_i to valid_o is two cycles when the output stage is free or being accepted.
// Backpressure: idx_o holds while ready_i is low; pending keeps collecting, duplicates merge.
module dl_pend_encoder_32p5p
    import dl_enc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ENC_VEC_W-1:0] set_i,
    input  logic                 flush_i,
    output logic [ENC_IDX_W-1:0] idx_o,
    output logic [ENC_VEC_W-1:0] onehot_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ENC_VEC_W-1:0] pending_o,
    output logic                 busy_o
);
    enc_vec_t pending_q, pending_d;
    enc_idx_t idx_q, idx_d;
    logic     valid_q, valid_d;

    enc_idx_t pick_idx;
    logic     pick_any;
    enc_vec_t pick_dec;
    enc_vec_t pick_mask;
    enc_vec_t out_dec;
    logic     load;

    dl_prienc_32p5p u_prienc (
        .vec_i (pending_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    dl_decoder_5p32p u_pick_dec (
        .idx_i    (pick_idx),
        .onehot_o (pick_dec)
    );

    dl_decoder_5p32p u_out_dec (
        .idx_i    (idx_q),
        .onehot_o (out_dec)
    );

    assign pick_mask = pick_dec & {ENC_VEC_W{pick_any}};
    assign load      = !valid_q || ready_i;

    // Next-state: flush wins over load; a same-cycle set re-marks a bit being moved out.
    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        if (flush_i) begin
            pending_d = set_i;
            valid_d   = 1'b0;
        end else begin
            if (load) begin
                valid_d = pick_any;
                if (pick_any) begin
                    idx_d = pick_idx;
                end
            end
            pending_d = (pending_q & ~(load ? pick_mask : '0)) | set_i;
        end
    end

    // State registers, cleared asynchronously so a held index is dropped without acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
        end
    end

    assign idx_o     = idx_q;
    assign valid_o   = valid_q;
    assign onehot_o  = out_dec & {ENC_VEC_W{valid_q}};
    assign pending_o = pending_q;
    assign busy_o    = valid_q || (pending_q != '0);
endmodule

// File: tb/tb_dl_pend_encoder_32p5p.sv
module tb_dl_pend_encoder_32p5p;
    logic        clk;
    logic        rst;
    logic [31:0] set_i;
    logic        flush_i;
    logic [4:0]  idx_o;
    logic [31:0] onehot_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pending_o;
    logic        busy_o;

    int errors;
    int checks;

    // reference model state
    logic [31:0] m_pend;
    logic        m_valid;
    logic [4:0]  m_idx;

    int got[$];
    int exp_q[$];

    dl_pend_encoder_32p5p dut (
        .clk       (clk),
        .rst       (rst),
        .set_i     (set_i),
        .flush_i   (flush_i),
        .idx_o     (idx_o),
        .onehot_o  (onehot_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pending_o (pending_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = '0;
    endtask

    task automatic check_outputs();
        chk("valid", {31'b0, valid_o}, {31'b0, m_valid});
        chk("idx", {27'b0, idx_o}, {27'b0, m_idx});
        chk("onehot", onehot_o, m_valid ? (32'h1 << m_idx) : 32'h0);
        chk("pending", pending_o, m_pend);
        chk("busy", {31'b0, busy_o}, {31'b0, (m_valid || m_pend != 0)});
    endtask

    // One clock: drive, check current outputs, record acceptance, advance model.
    task automatic step(input logic [31:0] s, input logic r, input logic f);
        int lo;
        logic ld;
        set_i   = s;
        ready_i = r;
        flush_i = f;
        check_outputs();
        if (valid_o && r && !f) got.push_back(int'(idx_o));
        @(posedge clk);
        if (f) begin
            m_pend  = s;
            m_valid = 1'b0;
        end else begin
            ld = !m_valid || r;
            lo = lowest(m_pend);
            if (ld) begin
                m_valid = (lo >= 0);
                if (lo >= 0) begin
                    m_idx  = lo[4:0];
                    m_pend[lo] = 1'b0;
                end
            end
            m_pend = m_pend | s;
        end
        #1;
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk(tag, got[i], exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        bit found;
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        set_i   = '0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        model_reset();
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // reset then idle
        for (int i = 0; i < 10; i++) step(32'h0, 1'b0, 1'b0);

        // single event
        step(32'h0000_0400, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(32'h0, 1'b1, 1'b0);
        exp_q = '{10};
        check_seq("single");

        // multi-hot with stall
        step(32'h8000_0011, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(32'h0, 1'b1, 1'b0);
        exp_q = '{0, 4, 31};
        check_seq("multi");

        // re-set of the bit being loaded, then lower bit overtakes
        step(32'h0000_0108, 1'b1, 1'b0);
        step(32'h0000_0008, 1'b1, 1'b0);
        step(32'h0000_0002, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(32'h0, 1'b1, 1'b0);
        exp_q = '{3, 1, 3, 8};
        check_seq("reset_bit");

        // flush with same-cycle set
        step(32'hFFFF_FFFF, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        step(32'h0000_0020, 1'b0, 1'b1);
        chk("flush_valid", {31'b0, valid_o}, 32'h0);
        chk("flush_pend", pending_o, 32'h0000_0020);
        for (int i = 0; i < 4; i++) step(32'h0, 1'b1, 1'b0);
        exp_q = '{5};
        check_seq("flush");

        // full drain
        step(32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 34; i++) step(32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        check_seq("drain");

        // full drain with async reset at index 17
        step(32'hFFFF_FFFF, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (valid_o && idx_o == 5'd17) found = 1'b1;
            else step(32'h0, 1'b1, 1'b0);
        end
        chk("reach17", {31'b0, found}, 32'h1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", {31'b0, valid_o}, 32'h0);
        chk("arst_idx", {27'b0, idx_o}, 32'h0);
        chk("arst_onehot", onehot_o, 32'h0);
        chk("arst_pend", pending_o, 32'h0);
        chk("arst_busy", {31'b0, busy_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        for (int i = 0; i < 3; i++) step(32'h0, 1'b1, 1'b0);
        chk("arst_no_emit", got.size(), 0);
        got.delete();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] s;
            s = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) s = '0;
            step(s, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 40; i++) step(32'h0, 1'b1, 1'b0);
        chk("final_busy", {31'b0, busy_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dl_pend_encoder_32p5p.md
Name: dl_pend_encoder_32p5p

Overview:
- Sequential 32-to-5 encoder: the inverse of the team's 5-to-32 one-hot decoder.
- Collects request pulses on a 32-bit vector into a pending register.
- Emits one 5-bit index per handshake, lowest index first, and clears that bit on acceptance.
- Used to serialise multi-hot events (register-file write notifications, interrupt/exception sources) into a single index stream for the RISC-V core.

Parameters:
- OUTPUT_WIDTH, 5, width of emitted index (localparam, fixed).
- INPUT_WIDTH, 32, width of request vector, equal to 2**OUTPUT_WIDTH (localparam, fixed).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- set_i  input  32  request pulses; any bit high for a cycle marks that index pending.
- flush_i  input  1  synchronous clear of pending register and output stage.
- idx_o  output  5  index being offered; meaningful only when valid_o=1.
- onehot_o  output  32  one-hot of idx_o; all zeros when valid_o=0.
- valid_o  output  1  idx_o holds an unaccepted index.
- ready_i  input  1  consumer accepts idx_o when valid_o and ready_i are both high at a clock edge.
- pending_o  output  32  current pending register (excludes the index held in the output stage).
- busy_o  output  1  high when pending_o is nonzero or valid_o=1.

Behaviour:
- Reset (rst high, any time, asynchronous): pending=0, valid_o=0, idx_o=0, onehot_o=0, busy_o=0. Reset mid-handshake discards the held index with no acceptance.
- State:
  - pending[31:0] register.
  - output stage: valid_o and idx_o registers.
  - onehot_o is decoded combinationally from idx_o and gated by valid_o.
- Definitions:
  - load = (!valid_o) | ready_i.
  - pick = lowest set bit index of pending (combinational priority encode); pick_mask = one-hot(pick) when pending≠0, else 0.
- Each edge when flush_i=0:
  - If load: valid_o <= (pending≠0); idx_o <= pick when pending≠0, else holds its old value.
  - pending <= (pending & ~(load ? pick_mask : 0)) | set_i.
- Set wins over clear: if set_i re-asserts the bit being moved out, the bit remains pending and is emitted again later. Requests are events; duplicates of an already-pending bit merge (no counting).
- flush_i=1 at an edge: pending <= set_i (same-cycle sets survive); valid_o <= 0. flush overrides load.
- Latency:
  - set_i bit k asserted in cycle 0 → pending[k]=1 in cycle 1 → valid_o=1, idx_o=k in cycle 2, provided the output stage was free or accepted in cycle 1.
- Throughput: one index per cycle with ready_i held high.
- Handshake rules:
  - idx_o must be stable while valid_o=1 and ready_i=0.
  - valid_o never drops without acceptance, except on flush_i or rst.
- Ordering: ascending index among bits pending at the moment of loading. A newly set lower index overtakes older higher ones.
- Empty: valid_o=0 with pending=0 is idle, and busy_o=0.
- Full: all 32 bits pending is legal. Drain takes 32 accepted cycles, indices 0..31 in order.
- No X on outputs after reset regardless of set_i history.

Decomposition:
- Shared package dl_enc_pkg:
  - localparams ENC_IDX_W=5 and ENC_VEC_W=32.
  - typedefs enc_idx_t (logic [4:0]) and enc_vec_t (logic [31:0]).
- Sub-modules:
  - Combinational priority encoder dl_prienc_32p5p: outputs lowest-set index and any-set flag.
  - Existing dl_decoder_5p32p instantiated to build pick_mask and onehot_o (outputs ANDed with the any-set or valid flag).
- Top-level owns only the registers and handshake logic.

Test Plan:
- Reset then idle: rst pulse, set_i=0 for 10 cycles → valid_o=0, onehot_o=0, busy_o=0, pending_o=0 throughout.
- Single event: set_i=32'h0000_0400 for one cycle, ready_i=1 → two cycles later valid_o=1, idx_o=10, onehot_o=32'h0000_0400 for exactly one cycle; then busy_o=0.
- Multi-hot with backpressure:
  - Stimulus: set_i=32'h8000_0011 once, ready_i=0 for 5 cycles, then ready_i=1.
  - Required: idx_o holds 0 stably while stalled, then 4, then 31 on consecutive cycles.
  - pending_o goes 32'h8000_0010 → 32'h8000_0000 → 0.
- Re-set during acceptance: pending bit 3 is being loaded while set_i=32'h8 in the same cycle → idx 3 emitted twice in total; a lower set_i bit 1 arriving later is emitted before any higher pending bit.
- Flush: pending=32'hFFFF_FFFF, valid_o=1; flush_i=1 together with set_i=32'h20 → next cycle valid_o=0, pending_o=32'h20; the next emitted idx is 5.
- Full drain and async reset:
  - set_i=32'hFFFF_FFFF once with ready_i=1 → idx_o 0..31 emitted in order on 32 consecutive cycles.
  - Repeat, asserting rst mid-drain at idx 17 → outputs go to 0 immediately, before the next edge.
